// File: rtl/uart_pkg.sv
// Shared definitions for the calculator UART transmit path: FSM state
// encoding, frame/divider defaults and the round-robin pick helper.
package uart_pkg;

  // 50 MHz system clock / 9600 baud.
  localparam int CLK_DIV_DEFAULT = 5208;

  // Bit periods per frame: start + 8 data + stop.
  localparam int FRAME_TICKS = 10;

  // Divider counter covers the full legal CLK_DIV range (2..65535).
  localparam int DIV_CNT_W = 16;

  // Frame tick counter; never needs to hold more than FRAME_TICKS-1.
  localparam int TICK_CNT_W = 4;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    SEND  = 2'd2
  } state_e;

  // Round-robin pick between two requesters. With both valid, the one not
  // served last time wins; otherwise the single valid one wins. The result
  // is a don't-care when neither is valid.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

endpackage : uart_pkg

// File: rtl/baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last count of each
// period with a one-cycle tick.
module baud_tick #(
  parameter int CLK_DIV = uart_pkg::CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import uart_pkg::*;

  localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt;

  // Free-running period counter, cleared by reset and wrapping at LAST.
  // NOTE: clocked state is written with <= only, so every register samples
  // the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decoded straight from the counter register so the tick lands in the
  // same cycle the count sits at LAST.
  assign tick = (cnt == LAST);

endmodule : baud_tick

// File: rtl/uart_tx_arbiter.sv
// Two-requester front end for the calculator's uart_tx. Flushes the shifter
// after reset, then loads one byte per frame on a bit-period tick, choosing
// between the keypad echo (requester 0) and the result formatter
// (requester 1) round-robin, with one spare idle bit between frames.
module uart_tx_arbiter #(
  parameter int CLK_DIV     = uart_pkg::CLK_DIV_DEFAULT,
  parameter int FRAME_TICKS = uart_pkg::FRAME_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_load,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant
);
  import uart_pkg::*;

  localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(FRAME_TICKS - 1);

  logic                  tick;
  state_e                state;
  logic [TICK_CNT_W-1:0] tick_cnt;
  logic                  grant_q;
  logic [7:0]            data_q;

  logic                  any_valid;
  logic                  win;
  logic [7:0]            win_data;
  logic                  accept;
  logic                  frame_done;

  baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Arbitration: pick the winner and its byte from the current requests.
  // NOTE: every signal assigned in always_comb gets a default on entry, so
  // no path can leave it holding a value and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    win       = 1'b0;
    win_data  = req0_data;
    any_valid = req0_valid || req1_valid;
    win       = rr_pick(req0_valid, req1_valid, grant_q);
    if (win) win_data = req1_data;
  end

  // A byte is taken only on a tick while IDLE. The load, the ready pulse and
  // the byte on tx_data must all land in the tick cycle itself so uart_tx
  // captures the byte on the same edge that starts its bit period; hence
  // these strobes are decoded from registered state and the tick rather than
  // delayed through another register.
  assign accept     = !rst && tick && (state == IDLE) && any_valid;
  assign frame_done = tick && (tick_cnt == LAST_TICK);

  // Frame sequencer: FLUSH and SEND both run for FRAME_TICKS ticks; the tick
  // that ends SEND cannot also load, which yields the extra idle bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FLUSH;
      tick_cnt <= '0;
    end else begin
      unique case (state)
        FLUSH, SEND: begin
          if (frame_done) begin
            state    <= IDLE;
            tick_cnt <= '0;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            state    <= SEND;
            tick_cnt <= '0;
          end
        end
        default: begin
          state    <= FLUSH;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Last-served requester and the last byte loaded; both move only on an
  // accepted request. Grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 1'b1;
      data_q  <= 8'h00;
    end else if (accept) begin
      grant_q <= win;
      data_q  <= win_data;
    end
  end

  // Outputs are forced to their reset values for every cycle rst is high,
  // including the first one before the registers have been cleared.
  assign tx_load    = accept;
  assign req0_ready = accept && !win;
  assign req1_ready = accept && win;
  assign tx_enable  = tick && !rst;
  assign tx_data    = rst ? 8'h00 : (accept ? win_data : data_q);
  assign busy       = rst || (state != IDLE);
  assign grant      = rst || grant_q;

  // The two ready strobes are mutually exclusive by construction.
  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  // A load only ever happens on a bit-period tick.
  a_load_on_tick : assert property (@(posedge clk) disable iff (rst)
    tx_load |-> tx_enable);

endmodule : uart_tx_arbiter
